// File: rtl/traffic_controller.sv
// Two-road traffic-light phase sequencer: PG -> PY -> SG -> SY -> PG, with PG
// held (green extension) until a secondary-road request has been latched.
// Ports: Clock/Reset (sync, active-high), SecondarySensor (level, in);
//        StateFlag[1:0], SecondsLeft[7:0], Tick, RequestPending (all registered, out).
module traffic_controller #(
   parameter int TICK_DIV = 50_000_000,
   parameter int PG_TIME  = 20,
   parameter int PY_TIME  = 3,
   parameter int SG_TIME  = 10,
   parameter int SY_TIME  = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       SecondarySensor,
   output logic [1:0] StateFlag,
   output logic [7:0] SecondsLeft,
   output logic       Tick,
   output logic       RequestPending
);

   localparam int CNT_W = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] PRESC_PRE  = CNT_W'(TICK_DIV - 2);

   localparam logic [7:0] PG_LOAD = 8'(PG_TIME);
   localparam logic [7:0] PY_LOAD = 8'(PY_TIME);
   localparam logic [7:0] SG_LOAD = 8'(SG_TIME);
   localparam logic [7:0] SY_LOAD = 8'(SY_TIME);

   typedef enum logic [1:0] {
      PG = 2'd0,
      PY = 2'd1,
      SG = 2'd2,
      SY = 2'd3
   } phase_t;

   phase_t           state;
   phase_t           state_nxt;
   logic [7:0]       secs_nxt;
   logic             req_nxt;
   logic [CNT_W-1:0] presc;

   assign StateFlag = state;

   // Tick is registered, so it is raised one count early: it is then high
   // exactly in the cycle where the prescaler holds TICK_DIV-1.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         presc          <= '0;
         Tick           <= 1'b0;
         state          <= PG;
         SecondsLeft    <= PG_LOAD;
         RequestPending <= 1'b0;
      end else begin
         presc          <= (presc == PRESC_LAST) ? '0 : presc + CNT_W'(1);
         Tick           <= (presc == PRESC_PRE);
         state          <= state_nxt;
         SecondsLeft    <= secs_nxt;
         RequestPending <= req_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      secs_nxt  = SecondsLeft;
      req_nxt   = RequestPending;

      // The sensor is ignored while the secondary road already has green.
      if (SecondarySensor && (state != SG))
         req_nxt = 1'b1;

      // Phase decisions use the registered request, so a request latched on
      // the same edge as an expiring PG tick waits for the following tick.
      if (Tick) begin
         if (SecondsLeft > 8'd1) begin
            secs_nxt = SecondsLeft - 8'd1;
         end else begin
            case (state)
               PG: begin
                  if (RequestPending) begin
                     state_nxt = PY;
                     secs_nxt  = PY_LOAD;
                  end else begin
                     secs_nxt  = 8'd0;   // green extension
                  end
               end
               PY: begin
                  state_nxt = SG;
                  secs_nxt  = SG_LOAD;
                  req_nxt   = 1'b0;      // clear wins over a same-edge set
               end
               SG: begin
                  state_nxt = SY;
                  secs_nxt  = SY_LOAD;
               end
               SY: begin
                  state_nxt = PG;
                  secs_nxt  = PG_LOAD;
               end
               default: begin
                  state_nxt = PG;
                  secs_nxt  = PG_LOAD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller with TICK_DIV=4 and short phase times.
// Expected observations are queued with the cycle (edges since reset release)
// at which they must hold, and are popped and compared as the run reaches them.
module tb_traffic_controller;

   logic       Clock;
   logic       Reset;
   logic       SecondarySensor;
   logic [1:0] StateFlag;
   logic [7:0] SecondsLeft;
   logic       Tick;
   logic       RequestPending;

   traffic_controller #(
      .TICK_DIV(4),
      .PG_TIME (3),
      .PY_TIME (2),
      .SG_TIME (2),
      .SY_TIME (1)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .SecondarySensor(SecondarySensor),
      .StateFlag      (StateFlag),
      .SecondsLeft    (SecondsLeft),
      .Tick           (Tick),
      .RequestPending (RequestPending)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic [7:0] secs;
      logic       req;
      logic       tick;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   failures;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic expect_at(input int c, input logic [1:0] st, input logic [7:0] secs,
                            input logic req, input logic tick, input string tag);
      exp_t e;
      e.cyc = c; e.st = st; e.secs = secs; e.req = req; e.tick = tick; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check($sformatf("%s.state@%0d", e.tag, e.cyc), {6'd0, StateFlag}, {6'd0, e.st});
         check($sformatf("%s.secs@%0d", e.tag, e.cyc), SecondsLeft, e.secs);
         check($sformatf("%s.req@%0d", e.tag, e.cyc), {7'd0, RequestPending}, {7'd0, e.req});
         check($sformatf("%s.tick@%0d", e.tag, e.cyc), {7'd0, Tick}, {7'd0, e.tick});
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
         cyc++;
         drain();
      end
   endtask

   task automatic do_reset(input int n);
      Reset = 1'b1;
      SecondarySensor = 1'b0;
      repeat (n) @(posedge Clock);
      #1;
      check("rst.state", {6'd0, StateFlag}, 8'd0);
      check("rst.secs", SecondsLeft, 8'd3);
      check("rst.req", {7'd0, RequestPending}, 8'd0);
      check("rst.tick", {7'd0, Tick}, 8'd0);
      Reset = 1'b0;
      cyc = 0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      Reset = 1'b1;
      SecondarySensor = 1'b0;

      // 1+2: reset, first tick, then no traffic for 100 clocks
      do_reset(2);
      expect_at(1,   2'd0, 8'd3, 1'b0, 1'b0, "idle");
      expect_at(2,   2'd0, 8'd3, 1'b0, 1'b0, "idle");
      expect_at(3,   2'd0, 8'd3, 1'b0, 1'b1, "first_tick");
      expect_at(4,   2'd0, 8'd2, 1'b0, 1'b0, "idle");
      expect_at(8,   2'd0, 8'd1, 1'b0, 1'b0, "idle");
      expect_at(11,  2'd0, 8'd1, 1'b0, 1'b1, "idle");
      expect_at(12,  2'd0, 8'd0, 1'b0, 1'b0, "extend");
      expect_at(99,  2'd0, 8'd0, 1'b0, 1'b1, "extend");
      expect_at(100, 2'd0, 8'd0, 1'b0, 1'b0, "extend");
      step(100);

      // 3: early one-clock request, full cycle back to PG
      do_reset(2);
      expect_at(2,  2'd0, 8'd3, 1'b1, 1'b0, "early");
      expect_at(11, 2'd0, 8'd1, 1'b1, 1'b1, "early");
      expect_at(12, 2'd1, 8'd2, 1'b1, 1'b0, "early_py");
      expect_at(16, 2'd1, 8'd1, 1'b1, 1'b0, "early_py");
      expect_at(19, 2'd1, 8'd1, 1'b1, 1'b1, "early_py");
      expect_at(20, 2'd2, 8'd2, 1'b0, 1'b0, "early_sg");
      expect_at(24, 2'd2, 8'd1, 1'b0, 1'b0, "early_sg");
      expect_at(28, 2'd3, 8'd1, 1'b0, 1'b0, "early_sy");
      expect_at(31, 2'd3, 8'd1, 1'b0, 1'b1, "early_sy");
      expect_at(32, 2'd0, 8'd3, 1'b0, 1'b0, "early_pg");
      step(1);
      SecondarySensor = 1'b1;
      step(1);
      SecondarySensor = 1'b0;
      step(30);

      // 4+5: late request on the tick edge while extended, then sensor only in SG
      do_reset(2);
      expect_at(39, 2'd0, 8'd0, 1'b0, 1'b1, "late");
      expect_at(40, 2'd0, 8'd0, 1'b1, 1'b0, "late_same_tick");
      expect_at(43, 2'd0, 8'd0, 1'b1, 1'b1, "late");
      expect_at(44, 2'd1, 8'd2, 1'b1, 1'b0, "late_py");
      expect_at(52, 2'd2, 8'd2, 1'b0, 1'b0, "sg_sensor");
      expect_at(56, 2'd2, 8'd1, 1'b0, 1'b0, "sg_sensor");
      expect_at(60, 2'd3, 8'd1, 1'b0, 1'b0, "sg_sensor");
      expect_at(61, 2'd3, 8'd1, 1'b0, 1'b0, "sy");
      expect_at(64, 2'd0, 8'd3, 1'b0, 1'b0, "pg_again");
      expect_at(76, 2'd0, 8'd0, 1'b0, 1'b0, "pg_hold");
      expect_at(88, 2'd0, 8'd0, 1'b0, 1'b0, "pg_hold");
      step(39);
      SecondarySensor = 1'b1;
      step(1);
      SecondarySensor = 1'b0;
      step(12);
      SecondarySensor = 1'b1;
      step(8);
      SecondarySensor = 1'b0;
      step(28);

      // 6: reset for one clock mid-SG, with the sensor and a pending tick on that edge
      do_reset(2);
      expect_at(22, 2'd2, 8'd2, 1'b0, 1'b0, "pre_rst_sg");
      expect_at(23, 2'd0, 8'd3, 1'b0, 1'b0, "mid_rst");
      expect_at(25, 2'd0, 8'd3, 1'b0, 1'b0, "post_rst");
      expect_at(26, 2'd0, 8'd3, 1'b0, 1'b1, "post_rst_tick");
      expect_at(27, 2'd0, 8'd2, 1'b0, 1'b0, "post_rst");
      step(1);
      SecondarySensor = 1'b1;
      step(1);
      SecondarySensor = 1'b0;
      step(20);
      Reset = 1'b1;
      SecondarySensor = 1'b1;
      step(1);
      Reset = 1'b0;
      SecondarySensor = 1'b0;
      step(4);

      checks++;
      assert (sb.size() == 0)
      else begin
         failures++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
